// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU, with a single-entry response register
// and per-requester saturating completion counters.
module alu_arbiter_alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] y,
  output logic         illegal
);
  logic [4:0] sh;
  assign sh = b[4:0];

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      4'd0:  y = a + b;
      4'd1:  y = a << sh;
      4'd2:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd3:  y = {{(N-1){1'b0}}, (a < b)};
      4'd4:  y = a ^ b;
      4'd5:  y = a >> sh;
      4'd6:  y = a | b;
      4'd7:  y = a & b;
      4'd12: y = a - b;
      4'd13: y = $signed(a) >>> sh;
      4'd15: y = b;
      default: illegal = 1'b1;
    endcase
  end
endmodule

module alu_arbiter_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
endmodule

module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [15:0]  cnt0,
  output logic [15:0]  cnt1
);
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
  } req_t;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  logic            rr_ptr;
  req_t [1:0]      req;
  req_t            sel;
  logic            grant0, grant1, can_accept, accept;
  logic [N-1:0]    alu_y;
  logic            alu_illegal;
  logic [1:0]      hs;
  logic [1:0][15:0] cnt;

  assign req[0] = {req0_a, req0_b, req0_op};
  assign req[1] = {req1_a, req1_b, req1_op};

  // rr_ptr only breaks ties; a lone valid requester always wins
  assign grant1     = req1_valid & (~req0_valid | rr_ptr);
  assign grant0     = req0_valid & ~grant1;
  assign can_accept = ~rsp_valid | rsp_ready;
  assign req0_ready = ~rst & grant0 & can_accept;
  assign req1_ready = ~rst & grant1 & can_accept;
  assign accept     = req0_ready | req1_ready;
  assign sel        = grant1 ? req[1] : req[0];

  alu_arbiter_alu #(.N(N)) u_alu (
    .a       (sel.a),
    .b       (sel.b),
    .op      (sel.op),
    .y       (alu_y),
    .illegal (alu_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rr_ptr     <= 1'b0;
    end else begin
      if (accept) rr_ptr <= ~grant1;
      case (state)
        EMPTY: if (accept) begin
          state      <= FULL;
          rsp_valid  <= 1'b1;
          rsp_result <= alu_illegal ? '0 : alu_y;
          rsp_id     <= grant1;
          rsp_err    <= alu_illegal;
        end
        FULL: if (accept) begin
          rsp_result <= alu_illegal ? '0 : alu_y;
          rsp_id     <= grant1;
          rsp_err    <= alu_illegal;
        end else if (rsp_ready) begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign hs[0] = rsp_valid & rsp_ready & ~rsp_id;
  assign hs[1] = rsp_valid & rsp_ready &  rsp_id;

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    alu_arbiter_cnt u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hs[i]),
      .cnt (cnt[i])
    );
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: a cycle model predicts grants and results at the negedge,
// expected responses are queued on accept and compared while held.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [15:0] cnt0, cnt1;

  typedef struct {
    logic [31:0] res;
    logic        id;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_full = 1'b0;
  logic        m_rr = 1'b0;
  logic [15:0] m_cnt[2] = '{16'd0, 16'd0};

  alu_arbiter #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic id);
    exp_t e;
    int   s;
    s     = int'(b[4:0]);
    e.id  = id;
    e.err = 1'b0;
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a << s;
      4'd2:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = a >> s;
      4'd6:  e.res = a | b;
      4'd7:  e.res = a & b;
      4'd12: e.res = a - b;
      4'd13: e.res = 32'($signed(a) >>> s);
      4'd15: e.res = b;
      default: begin e.res = 32'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // cycle model: checks held response, grants and counters, then advances one edge
  always @(negedge clk) begin
    logic g0, g1, can, r0, r1, hs;
    if (rst) begin
      chk("rst_rdy0", req0_ready, 1'b0);
      chk("rst_rdy1", req1_ready, 1'b0);
      m_full = 1'b0; m_rr = 1'b0; m_cnt[0] = '0; m_cnt[1] = '0;
      sbq.delete();
    end else begin
      chk("rsp_valid", rsp_valid, m_full);
      chk("cnt0", cnt0, m_cnt[0]);
      chk("cnt1", cnt1, m_cnt[1]);
      if (m_full && sbq.size() > 0) begin
        chk("rsp_result", rsp_result, sbq[0].res);
        chk("rsp_id", rsp_id, sbq[0].id);
        chk("rsp_err", rsp_err, sbq[0].err);
      end
      can = !m_full || rsp_ready;
      g1  = req1_valid && (!req0_valid || m_rr);
      g0  = req0_valid && !g1;
      r0  = g0 && can;
      r1  = g1 && can;
      chk("req0_ready", req0_ready, r0);
      chk("req1_ready", req1_ready, r1);
      hs = m_full && rsp_ready;
      if (hs && sbq.size() > 0) begin
        if (m_cnt[sbq[0].id] != 16'hFFFF) m_cnt[sbq[0].id]++;
        void'(sbq.pop_front());
      end
      if (r0 || r1) begin
        sbq.push_back(r1 ? model(req1_op, req1_a, req1_b, 1'b1) : model(req0_op, req0_a, req0_b, 1'b0));
        m_rr   = r1 ? 1'b0 : 1'b1;
        m_full = 1'b1;
      end else if (hs) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    logic [15:0] c0;
    rst = 1'b1; rsp_ready = 1'b0;
    set0(1'b1, 4'd0, 32'd0, 32'd0);
    set1(1'b1, 4'd0, 32'd0, 32'd0);
    repeat (2) step();
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_id", rsp_id, 1'b0);
    chk("reset_err", rsp_err, 1'b0);
    chk("reset_cnt0", cnt0, 16'd0);
    chk("reset_cnt1", cnt1, 16'd0);
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b0;

    // single add from requester 0
    rsp_ready = 1'b1;
    set0(1'b1, 4'd0, 32'd5, 32'd7);
    step();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    chk("add_valid", rsp_valid, 1'b1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_id", rsp_id, 1'b0);
    step();
    chk("add_cnt0", cnt0, 16'd1);

    // reset, then contention: grants alternate 0,1,0,1
    rst = 1'b1; step(); rst = 1'b0;
    set0(1'b1, 4'd0, 32'd100, 32'd1);
    set1(1'b1, 4'd12, 32'd100, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_id", rsp_id, 32'(i % 2));
      chk("rr_valid", rsp_valid, 1'b1);
    end
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    step();

    // shifts and compares on requester 1
    set1(1'b1, 4'd13, 32'h8000_0000, 32'd4); step();
    chk("sra_result", rsp_result, 32'hF800_0000);
    chk("sra_id", rsp_id, 1'b1);
    set1(1'b1, 4'd3, 32'd1, 32'hFFFF_FFFF); step();
    chk("sltu_result", rsp_result, 32'd1);
    set1(1'b1, 4'd2, 32'd1, 32'hFFFF_FFFF); step();
    chk("slt_result", rsp_result, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    step();

    // illegal op
    c0 = cnt0;
    set0(1'b1, 4'd9, 32'd3, 32'd4); step();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    chk("ill_result", rsp_result, 32'd0);
    chk("ill_err", rsp_err, 1'b1);
    step();
    chk("ill_cnt0", cnt0, c0 + 16'd1);

    // randomized traffic with backpressure
    for (int i = 0; i < 60; i++) begin
      set0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(), $urandom());
      set1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(), $urandom());
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    step();

    // stall: held response stable, req1 blocked, operand changes ignored
    rsp_ready = 1'b0;
    set0(1'b1, 4'd0, 32'd1, 32'd2); step();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      set1(1'b1, 4'd0, 32'(i * 7), 32'(i + 100));
      #1;
      chk("stall_rdy1", req1_ready, 1'b0);
      chk("stall_result", rsp_result, 32'd3);
      chk("stall_valid", rsp_valid, 1'b1);
      step();
    end
    set1(1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    rsp_ready = 1'b1;
    #1;
    chk("unstall_rdy1", req1_ready, 1'b1);
    step();
    chk("unstall_result", rsp_result, 32'h0000_00FF);
    chk("unstall_id", rsp_id, 1'b1);

    // reset while FULL drops the held response uncounted
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", rsp_valid, 1'b0);
    chk("mrst_cnt0", cnt0, 16'd0);
    chk("mrst_cnt1", cnt1, 16'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, 4'd15, 32'd0, 32'd11);
    set1(1'b1, 4'd15, 32'd0, 32'd22);
    #1;
    chk("mrst_tie0", req0_ready, 1'b1);
    chk("mrst_tie1", req1_ready, 1'b0);
    step();
    chk("mrst_id", rsp_id, 1'b0);
    chk("mrst_res", rsp_result, 32'd11);
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
